prefetch_queue: RTL and testbench
=================================

Name: prefetch_queue

Overview:
Parametrised instruction prefetch queue between the APB fetch interface and the decode stage.
- Accepts fetch words carrying SLOTS instructions each, and stores each instruction with its own PC.
- Presents one instruction per cycle to decode in program order.
- Absorbs the fetch-side latency, honours decode stalls, and supports flush on branch redirect.
- Replaces the fixed two-instruction single-entry prefetch buffer with a DEPTH-entry circular queue with occupancy tracking and backpressure.

Parameters:
INST_W, 16, instruction width in bits
SLOTS, 2, instructions per fetch word (>=1)
DEPTH, 4, queue capacity in instructions; power of two, DEPTH >= SLOTS
PC_W, 32, PC width
PC_STEP, 2, PC increment between consecutive instructions

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  system reset, synchronous, active-low
fill_valid  in  1  fetch word present
fill_ready  out  1  queue can accept a full fetch word this cycle
fill_data  in  SLOTS*INST_W  fetch word; slot 0 in bits [INST_W-1:0] is the first in program order
fill_pc  in  PC_W  PC of slot 0
stall  in  1  decode not consuming this cycle
flush  in  1  discard all queued instructions (branch redirect)
inst_valid  out  1  inst/inst_pc hold a valid head instruction
inst  out  INST_W  head instruction
inst_pc  out  PC_W  PC of head instruction
count  out  $clog2(DEPTH+1)  current occupancy in instructions

Behaviour:
- Reset (rst==0 at a rising edge):
  - rd_ptr, wr_ptr and count are cleared to 0.
  - Storage is cleared to 0, so inst=0, inst_pc=0 and inst_valid=0.
  - fill_ready is forced 0 while rst==0.
  - Reset asserted mid-operation discards all contents in that same edge.
- Push: push = fill_valid & fill_ready & ~flush.
  - Writes SLOTS entries at wr_ptr..wr_ptr+SLOTS-1, modulo DEPTH.
  - Entry k holds fill_data slot k and PC fill_pc + k*PC_STEP, truncated to PC_W.
  - wr_ptr advances by SLOTS, wrapping modulo DEPTH.
- fill_ready = (DEPTH - count) >= SLOTS, from registered count only. There is no credit for a same-cycle pop, and no partial-word accept.
- Pop: pop = inst_valid & ~stall & ~flush.
  - rd_ptr advances by 1 and count decrements.
- Outputs:
  - inst_valid = (count != 0).
  - inst and inst_pc are driven from the entry at rd_ptr.
  - When count==0, inst and inst_pc hold the last entry read; they are don't-care to consumers.
- Latency: a word accepted at edge N is visible at the head after edge N, provided the queue was empty.
- Simultaneous push and pop: count_next = count + SLOTS - 1.
- Flush priority:
  - flush==1 sets count=0 and rd_ptr=wr_ptr next edge.
  - Any fill offered that cycle is dropped, and the head is not consumed.
  - inst_valid=0 on the following cycle.
- Stall: while stall==1, the head entry, inst, inst_pc and rd_ptr are stable. Pushes continue up to capacity.
- Overflow and underflow cannot occur by construction. fill_valid while fill_ready==0 has no effect, and the source holds its word.

Optional Feature:
PREFETCH_BYPASS_EN
- Defined:
  - When count==0 and a push occurs, inst_valid=1 in the same cycle, with inst = fill_data slot 0 and inst_pc = fill_pc driven combinationally.
  - If decode pops that cycle (stall==0), only slots 1..SLOTS-1 are written and count_next = SLOTS-1.
  - Otherwise all SLOTS are written.
  - Zero-cycle fill-to-decode latency.
- Undefined:
  - No combinational fill-to-output path.
  - Latency is one cycle, as described above.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with fill_valid=1 → inst_valid=0, inst=0, inst_pc=0, count=0, fill_ready=0. Release → fill_ready=1.
2. Push fill_data=0xBBBB_AAAA, fill_pc=0x100, stall=0 → next cycle inst=0xAAAA, pc=0x100. Following cycle inst=0xBBBB, pc=0x102. Then inst_valid=0, count=0.
3. Stall=1, push 2 words (pc 0x100, 0x104) → count=4, fill_ready=0. A third offered word is not accepted. Release stall for 1 cycle → count=3, fill_ready still 0. Second release → count=2, fill_ready=1.
4. Stall=1 for 5 cycles with head 0xAAAA/0x100 → inst and inst_pc are unchanged every cycle, and count rises only to capacity.
5. With count=3, assert flush and fill_valid together → next cycle count=0, inst_valid=0, and the offered word is lost. The next push at pc=0x300 appears as head 0x300.
6. Stream 10 words (pc 0x200 step 4) with stall=0 throughout → 20 instructions emerge in order, pc 0x200..0x226. Pointers wrap at least 4 times, with no loss or duplication.

Source files
------------

// File: rtl/prefetch_queue.sv
// prefetch_queue: instruction prefetch queue between the fetch interface and decode.
// Fetch words of SLOTS instructions are split into a DEPTH-entry circular queue,
// each entry tagged with its own PC, and handed to decode one per cycle.
// Optional build macro: PREFETCH_BYPASS_EN adds a zero-latency path from an empty
// queue straight to the decode outputs.
module prefetch_queue #(
    parameter int INST_W  = 16,
    parameter int SLOTS   = 2,
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int PC_STEP = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fill_valid,
    output logic                         fill_ready,
    input  logic [SLOTS*INST_W-1:0]      fill_data,
    input  logic [PC_W-1:0]              fill_pc,
    input  logic                         stall,
    input  logic                         flush,
    output logic                         inst_valid,
    output logic [INST_W-1:0]            inst,
    output logic [PC_W-1:0]              inst_pc,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;

    logic              push;
    logic              pop;
    logic              head_valid;
    logic              bypass;
    logic              skip;
    logic              rd_adv;
    int                n_wr;
    logic [PW-1:0]     wr_idx  [SLOTS];
    logic [PC_W-1:0]   slot_pc [SLOTS];
    logic [PW-1:0]     wr_ptr_nxt;
    logic [PW-1:0]     rd_ptr_nxt;
    logic [CW-1:0]     cnt_nxt;

    // Backpressure from registered occupancy only: a whole word must fit.
    assign fill_ready = rst & (cnt <= CW'(DEPTH - SLOTS));
    assign push       = fill_valid & fill_ready & ~flush;

`ifdef PREFETCH_BYPASS_EN
    // An empty queue forwards slot 0 of an accepted word to decode in the same cycle.
    assign bypass     = push & (cnt == '0);
    assign head_valid = (cnt != '0) | bypass;
    assign inst       = bypass ? fill_data[INST_W-1:0] : mem_inst[rd_ptr];
    assign inst_pc    = bypass ? fill_pc : mem_pc[rd_ptr];
`else
    assign bypass     = 1'b0;
    assign head_valid = (cnt != '0);
    assign inst       = mem_inst[rd_ptr];
    assign inst_pc    = mem_pc[rd_ptr];
`endif

    assign pop        = head_valid & ~stall & ~flush;
    // A bypassed instruction consumed immediately is never stored.
    assign skip       = bypass & pop;
    assign inst_valid = head_valid;
    assign count      = cnt;

    // Write addresses, per-slot PCs and next pointer/occupancy values.
    always_comb begin
        rd_adv = pop & ~skip;
        n_wr   = 0;
        if (push) begin
            n_wr = SLOTS - int'(skip);
        end
        for (int k = 0; k < SLOTS; k++) begin
            wr_idx[k]  = PW'((int'(wr_ptr) + k + DEPTH - int'(skip)) % DEPTH);
            slot_pc[k] = fill_pc + PC_W'(k * PC_STEP);
        end
        wr_ptr_nxt = PW'((int'(wr_ptr) + n_wr) % DEPTH);
        rd_ptr_nxt = PW'((int'(rd_ptr) + int'(rd_adv)) % DEPTH);
        cnt_nxt    = cnt + CW'(n_wr) - CW'(rd_adv);
    end

    // Queue storage, pointers and occupancy; flush outranks push and pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_inst[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else if (flush) begin
            cnt    <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                for (int k = 0; k < SLOTS; k++) begin
                    if (!(skip && (k == 0))) begin
                        mem_inst[wr_idx[k]] <= fill_data[k*INST_W +: INST_W];
                        mem_pc[wr_idx[k]]   <= slot_pc[k];
                    end
                end
            end
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
// tb_prefetch_queue: directed bench for prefetch_queue with a queue-based reference model.
module tb_prefetch_queue;

    localparam int INST_W  = 16;
    localparam int SLOTS   = 2;
    localparam int DEPTH   = 4;
    localparam int PC_W    = 32;
    localparam int PC_STEP = 2;
    localparam int CW      = $clog2(DEPTH+1);

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    fill_valid;
    logic                    fill_ready;
    logic [SLOTS*INST_W-1:0] fill_data;
    logic [PC_W-1:0]         fill_pc;
    logic                    stall;
    logic                    flush;
    logic                    inst_valid;
    logic [INST_W-1:0]       inst;
    logic [PC_W-1:0]         inst_pc;
    logic [CW-1:0]           count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [INST_W-1:0] i;
        logic [PC_W-1:0]   p;
    } ent_t;

    ent_t mq[$];
    ent_t popped[$];
    bit   started = 1'b0;

    prefetch_queue #(
        .INST_W(INST_W), .SLOTS(SLOTS), .DEPTH(DEPTH), .PC_W(PC_W), .PC_STEP(PC_STEP)
    ) dut (
        .clk(clk), .rst(rst), .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_data(fill_data), .fill_pc(fill_pc), .stall(stall), .flush(flush),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the queue as a list of (inst, pc) pairs updated on each rising edge.
    always @(posedge clk) begin
        int sz;
        sz = mq.size();
        started = 1'b1;
        if (!rst || flush) begin
            mq.delete();
        end else begin
            if (sz != 0 && !stall) void'(mq.pop_front());
            if (fill_valid && (DEPTH - sz >= SLOTS)) begin
                for (int k = 0; k < SLOTS; k++) begin
                    ent_t e;
                    e.i = fill_data[k*INST_W +: INST_W];
                    e.p = fill_pc + PC_W'(k * PC_STEP);
                    mq.push_back(e);
                end
            end
        end
    end

    // Compare DUT against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (started) begin
            chk("m_count", 64'(count), 64'(mq.size()));
            chk("m_valid", 64'(inst_valid), 64'(mq.size() != 0));
            chk("m_ready", 64'(fill_ready), 64'(rst && (DEPTH - mq.size() >= SLOTS)));
            if (mq.size() != 0) begin
                chk("m_inst", 64'(inst), 64'(mq[0].i));
                chk("m_pc", 64'(inst_pc), 64'(mq[0].p));
            end
            if (rst && inst_valid && !stall && !flush) begin
                ent_t e;
                e.i = inst;
                e.p = inst_pc;
                popped.push_back(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int guard;
        bit acc;

        // 1: reset held with a word offered
        rst = 1'b0; fill_valid = 1'b1; fill_data = 32'h1234_5678; fill_pc = 32'h40;
        stall = 1'b0; flush = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        chk("rst_inst", 64'(inst), 64'd0);
        chk("rst_pc", 64'(inst_pc), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(fill_ready), 64'd0);
        rst = 1'b1; fill_valid = 1'b0;
        #1;
        chk("rel_ready", 64'(fill_ready), 64'd1);

        // 2: single word, one cycle latency, then drains
        tick();
        fill_valid = 1'b1; fill_data = 32'hBBBB_AAAA; fill_pc = 32'h100;
        tick();
        fill_valid = 1'b0;
        @(negedge clk);
        chk("t2_inst0", 64'(inst), 64'hAAAA);
        chk("t2_pc0", 64'(inst_pc), 64'h100);
        tick();
        @(negedge clk);
        chk("t2_inst1", 64'(inst), 64'hBBBB);
        chk("t2_pc1", 64'(inst_pc), 64'h102);
        tick();
        @(negedge clk);
        chk("t2_empty_valid", 64'(inst_valid), 64'd0);
        chk("t2_empty_count", 64'(count), 64'd0);

        // 3: stall fills to capacity, backpressure, release one at a time
        stall = 1'b1; fill_valid = 1'b1; fill_data = 32'h2222_1111; fill_pc = 32'h100;
        tick();
        fill_data = 32'h4444_3333; fill_pc = 32'h104;
        tick();
        @(negedge clk);
        chk("t3_full_count", 64'(count), 64'd4);
        chk("t3_full_ready", 64'(fill_ready), 64'd0);
        fill_data = 32'h6666_5555; fill_pc = 32'h108;
        tick();
        @(negedge clk);
        chk("t3_third_count", 64'(count), 64'd4);
        stall = 1'b0;
        tick();
        stall = 1'b1; fill_valid = 1'b0;
        @(negedge clk);
        chk("t3_rel1_count", 64'(count), 64'd3);
        chk("t3_rel1_ready", 64'(fill_ready), 64'd0);
        chk("t3_rel1_inst", 64'(inst), 64'h2222);
        stall = 1'b0;
        tick();
        stall = 1'b1;
        @(negedge clk);
        chk("t3_rel2_count", 64'(count), 64'd2);
        chk("t3_rel2_ready", 64'(fill_ready), 64'd1);
        chk("t3_rel2_pc", 64'(inst_pc), 64'h104);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("t3_flush_count", 64'(count), 64'd0);

        // 4: long stall keeps head stable while pushes saturate
        stall = 1'b1; fill_valid = 1'b1; fill_data = 32'hBBBB_AAAA; fill_pc = 32'h100;
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            chk("t4_inst", 64'(inst), 64'hAAAA);
            chk("t4_pc", 64'(inst_pc), 64'h100);
            chk("t4_count", 64'(count), (c == 0) ? 64'd2 : 64'd4);
        end
        fill_valid = 1'b0;

        // 5: flush with a concurrent fill drops the fill
        stall = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_pre_count", 64'(count), 64'd3);
        flush = 1'b1; fill_valid = 1'b1; fill_data = 32'hDDDD_CCCC; fill_pc = 32'h500;
        tick();
        flush = 1'b0; fill_data = 32'h3302_3300; fill_pc = 32'h300; stall = 1'b1;
        @(negedge clk);
        chk("t5_flush_count", 64'(count), 64'd0);
        chk("t5_flush_valid", 64'(inst_valid), 64'd0);
        tick();
        fill_valid = 1'b0;
        @(negedge clk);
        chk("t5_head_pc", 64'(inst_pc), 64'h300);
        chk("t5_head_inst", 64'(inst), 64'h3300);
        stall = 1'b0;
        tick();
        @(negedge clk);
        chk("t5_next_pc", 64'(inst_pc), 64'h302);
        tick();
        @(negedge clk);
        chk("t5_drained", 64'(count), 64'd0);

        // 6: stream 10 words without stalls; pointers wrap repeatedly
        popped.delete();
        i = 0; guard = 0;
        while (i < 10 && guard < 200) begin
            fill_valid = 1'b1;
            fill_data  = {16'(16'hA000 + 2*i + 1), 16'(16'hA000 + 2*i)};
            fill_pc    = 32'h200 + 32'(4*i);
            acc = fill_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        fill_valid = 1'b0;
        chk("t6_accept_budget", 64'(i), 64'd10);
        guard = 0;
        while (count != 0 && guard < 50) begin
            tick();
            guard++;
        end
        chk("t6_drain_budget", 64'(guard < 50), 64'd1);
        @(negedge clk);
        chk("t6_popped_n", 64'(popped.size()), 64'd20);
        for (int j = 0; j < 20 && j < popped.size(); j++) begin
            chk("t6_pc", 64'(popped[j].p), 64'(32'h200 + 32'(2*j)));
            chk("t6_inst", 64'(popped[j].i), 64'(16'hA000 + 16'(j)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
